// File: rtl/ps2_init_seq.sv
// PS/2 mouse initialisation sequencer: reset the device, wait for its BAT and ID,
// set the sample rate and enable streaming, with per-command resend and timeout.
module ps2_init_seq #(
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter int         TIMEOUT     = 25_000_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stream_en,
    output logic       busy,
    output logic       error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_C   = CW'(TIMEOUT);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_BAT, S_WAIT_ID, S_READY, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    index_q, index_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_s;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          stream_en_q, stream_en_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'hFF;
            2'd1:    b = 8'hF3;
            2'd2:    b = SAMPLE_RATE;
            2'd3:    b = 8'hF4;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // Next-state, command index, retry and timeout bookkeeping.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        retry_d   = retry_q;
        timeout_s = (cnt_q == TIMEOUT_C);
        case (state_q)
            S_IDLE, S_READY, S_FAIL: begin
                if (start) begin
                    state_d = S_SEND;
                    index_d = 2'd0;
                    retry_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SEND: begin
                if (tx_ready) state_d = S_WAIT_ACK;
                else          state_d = S_SEND;
            end
            S_WAIT_ACK: begin
                if (rx_valid && rx_data == 8'hFA) begin
                    retry_d = '0;
                    case (index_q)
                        2'd0:    state_d = S_WAIT_BAT;
                        2'd3:    state_d = S_READY;
                        default: begin
                            index_d = index_q + 2'd1;
                            state_d = S_SEND;
                        end
                    endcase
                end else if ((rx_valid && rx_data == 8'hFE) || timeout_s) begin
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_BAT, S_WAIT_ID: begin
                if (rx_valid && state_q == S_WAIT_ID) begin
                    retry_d = '0;
                    index_d = 2'd1;
                    state_d = S_SEND;
                end else if (rx_valid && rx_data == 8'hAA) begin
                    retry_d = '0;
                    state_d = S_WAIT_ID;
                end else if (rx_valid && rx_data == 8'hFC) begin
                    state_d = S_FAIL;
                end else if (timeout_s) begin
                    // A lost BAT/ID restarts the whole sequence from the reset command.
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + RW'(1);
                        index_d = 2'd0;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter restarts on any state change, which covers every accepted byte.
        if ((state_q == S_WAIT_ACK || state_q == S_WAIT_BAT || state_q == S_WAIT_ID)
            && state_d == state_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Output next values are decoded from the next state so outputs align with the state.
    always_comb begin
        tx_valid_d  = (state_d == S_SEND);
        if (state_d == S_SEND) tx_data_d = cmd_byte(index_d);
        else                   tx_data_d = 8'h00;
        busy_d      = (state_d == S_SEND) || (state_d == S_WAIT_ACK) ||
                      (state_d == S_WAIT_BAT) || (state_d == S_WAIT_ID);
        stream_en_d = (state_d == S_READY);
        error_d     = (state_d == S_FAIL);
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= 2'd0;
            retry_q     <= '0;
            cnt_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            stream_en_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            stream_en_q <= stream_en_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign stream_en = stream_en_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ps2_init_seq.sv
// Directed bench for ps2_init_seq: a vector table for the nominal flow plus
// hand-written sequences for backpressure, resend, timeout failure, BAT failure and reset.
module tb_ps2_init_seq;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       stream_en;
    logic       busy;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_log[$];

    ps2_init_seq #(.SAMPLE_RATE(8'd100), .TIMEOUT(100), .MAX_RETRY(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .stream_en(stream_en),
        .busy     (busy),
        .error    (error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    typedef struct packed {
        logic       start;
        logic       txr;
        logic       rxv;
        logic [7:0] rxd;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_se;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [11:0] outs();
        return {tx_valid, tx_data, stream_en, busy, error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_sent(input int n);
        int k = 0;
        while (tx_log.size() < n && k < 300) begin
            step();
            k++;
        end
        check($sformatf("tx_count_reaches_%0d", n), tx_log.size(), n);
    endtask

    function automatic int count_byte(input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < tx_log.size(); i++) if (tx_log[i] == b) c++;
        return c;
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'hFA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hF3, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'hFA, 1'b1, 8'h64, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hFA, 1'b1, 8'hF4, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hFA, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        // Reset state, then idle without start.
        step();
        step();
        check("reset_outputs", outs(), 12'h000);
        reset = 1'b0;
        repeat (3) step();
        check("idle_after_reset", outs(), 12'h000);

        // Nominal flow from the table.
        for (int i = 0; i < 12; i++) begin
            start    = vecs[i].start;
            tx_ready = vecs[i].txr;
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            step();
            check($sformatf("nominal_vec_%0d", i), outs(),
                  {vecs[i].e_txv, vecs[i].e_txd, vecs[i].e_se, vecs[i].e_busy, vecs[i].e_err});
        end
        start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        check("nominal_tx_count", tx_log.size(), 4);
        check("nominal_tx_order", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'hFFF364F4);

        // Backpressure on the first command.
        tx_log.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("backpressure_hold_%0d", i), {tx_valid, tx_data}, {1'b1, 8'hFF});
        end
        tx_ready = 1'b1;
        step();
        check("backpressure_one_sent", tx_log.size(), 1);
        check("backpressure_released", {tx_valid, busy}, 2'b01);

        // Resend of 0xF3 twice, then complete.
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_sent(2);
        rx_byte(8'hFE);
        wait_sent(3);
        rx_byte(8'hFE);
        wait_sent(4);
        rx_byte(8'hFA);
        wait_sent(5);
        rx_byte(8'hFA);
        wait_sent(6);
        rx_byte(8'hFA);
        check("resend_f3_count", count_byte(8'hF3), 3);
        check("resend_complete", {stream_en, busy, error}, 3'b100);

        // No replies: 0xFF sent four times, then failure.
        tx_log.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 1000 && !error; k++) step();
        check("timeout_error", error, 1'b1);
        check("timeout_not_busy", {busy, stream_en, tx_valid}, 3'b000);
        check("timeout_ff_sends", count_byte(8'hFF), 4);
        check("timeout_total_sends", tx_log.size(), 4);

        // Restart clears error and resends 0xFF; then BAT failure.
        tx_log.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_clears_error", {tx_valid, tx_data, error, busy}, {1'b1, 8'hFF, 1'b0, 1'b1});
        wait_sent(1);
        rx_byte(8'hFA);
        rx_byte(8'hFC);
        check("bat_fail", {error, busy, stream_en}, 3'b100);
        begin
            int txv_seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (tx_valid) txv_seen++;
            end
            check("bat_fail_no_tx", txv_seen, 0);
        end

        // Start ignored while busy, then reset mid-WAIT_ACK.
        tx_log.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_sent(1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ignored_busy", {tx_valid, busy}, 2'b01);
        step();
        check("start_ignored_sends", tx_log.size(), 1);
        reset = 1'b1;
        #1;
        check("reset_mid_wait", outs(), 12'h000);
        step();
        reset = 1'b0;
        step();
        rx_byte(8'hFA);
        repeat (3) step();
        check("rx_in_idle", outs(), 12'h000);
        check("rx_in_idle_no_tx", tx_log.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
